// File: rtl/alu_driver.sv
// Command FIFO plus single-outstanding ALU sequencer: queues opcode/operand commands,
// issues them one at a time to an external ALU and returns result/status responses.
module alu_driver #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_opcode,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   output logic [2:0]  alu_opcode,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   input  logic [15:0] alu_result,
   input  logic        alu_valid,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_result,
   output logic [1:0]  rsp_status
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic [1:0]    ST_OK      = 2'b00;
   localparam logic [1:0]    ST_INVALID = 2'b01;
   localparam logic [1:0]    ST_TIMEOUT = 2'b10;
   localparam logic [15:0]   DEAD       = 16'hDEAD;
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

   typedef struct packed {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
   } cmd_t;

   cmd_t          mem_q [FIFO_DEPTH];
   cmd_t          mem_d [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          cmd_ready_q, cmd_ready_d;
   logic [1:0]    state_q, state_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [2:0]    alu_opcode_q, alu_opcode_d;
   logic [7:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [15:0]   rsp_result_q, rsp_result_d;
   logic [1:0]    rsp_status_q, rsp_status_d;
   logic          enq_s, deq_s;
   cmd_t          head_s;

   // FIFO bookkeeping; cmd_ready is registered from the post-update count
   always_comb begin
      enq_s  = cmd_valid && cmd_ready_q;
      deq_s  = (state_q == S_IDLE) && (count_q != {CW{1'b0}});
      head_s = mem_q[rd_ptr_q];
      mem_d  = mem_q;
      if (enq_s) begin
         mem_d[wr_ptr_q] = '{op: cmd_opcode, a: cmd_a, b: cmd_b};
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (deq_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({enq_s, deq_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      cmd_ready_d = (count_d != FULL_COUNT);
   end

   // Sequencer: the dequeued entry is loaded straight into the ALU drive registers
   always_comb begin
      state_d      = state_q;
      tmo_d        = tmo_q;
      alu_opcode_d = alu_opcode_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_status_d = rsp_status_q;
      case (state_q)
         S_IDLE: begin
            if (deq_s) begin
               alu_opcode_d = head_s.op;
               alu_a_d      = head_s.a;
               alu_b_d      = head_s.b;
               state_d      = S_ISSUE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            tmo_d   = {TW{1'b0}};
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // a valid result wins even if its value happens to be DEAD
            if (alu_valid) begin
               rsp_result_d = alu_result;
               rsp_status_d = ST_OK;
               rsp_valid_d  = 1'b1;
               state_d      = S_RESP;
            end else if (alu_result == DEAD) begin
               rsp_result_d = DEAD;
               rsp_status_d = ST_INVALID;
               rsp_valid_d  = 1'b1;
               state_d      = S_RESP;
            end else if (tmo_q == TMO_LAST) begin
               rsp_result_d = 16'h0000;
               rsp_status_d = ST_TIMEOUT;
               rsp_valid_d  = 1'b1;
               state_d      = S_RESP;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end else begin
               state_d = S_RESP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // All state; reset discards queued and in-flight commands immediately
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= {$bits(cmd_t){1'b0}};
         end
         wr_ptr_q     <= {PW{1'b0}};
         rd_ptr_q     <= {PW{1'b0}};
         count_q      <= {CW{1'b0}};
         cmd_ready_q  <= 1'b0;
         state_q      <= S_IDLE;
         tmo_q        <= {TW{1'b0}};
         alu_opcode_q <= 3'b000;
         alu_a_q      <= 8'h00;
         alu_b_q      <= 8'h00;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= 16'h0000;
         rsp_status_q <= 2'b00;
      end else begin
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         cmd_ready_q  <= cmd_ready_d;
         state_q      <= state_d;
         tmo_q        <= tmo_d;
         alu_opcode_q <= alu_opcode_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_status_q <= rsp_status_d;
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign alu_opcode = alu_opcode_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_status = rsp_status_q;

endmodule
